// File: rtl/slot_ctrl_pkg.sv
// rtl/slot_ctrl_pkg.sv - shared states, slot codes and op kinds for the slot save/load controller
// ST_VERIFY exists only when SLOT_READBACK_EN is defined.
package slot_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
`ifdef SLOT_READBACK_EN
    , ST_VERIFY
`endif
  } state_t;

  typedef enum logic {
    OP_SAVE = 1'b0,
    OP_LOAD = 1'b1
  } op_t;

  localparam logic [31:0] NONE = 32'd0;
  localparam logic [31:0] LOC1 = 32'd1;
  localparam logic [31:0] LOC2 = 32'd2;
  localparam logic [31:0] LOC3 = 32'd3;

  function automatic logic code_is_slot(input logic [31:0] code);
    return (code >= LOC1) && (code <= LOC3);
  endfunction

endpackage

// File: rtl/slot_req_detect.sv
// rtl/slot_req_detect.sv - level-change event detection and single-entry pending request for one requester
module slot_req_detect
  import slot_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic [31:0]       code,
  input  logic [DATA_W-1:0] data,
  input  logic              grant,
  output logic              pending,
  output logic [1:0]        slot,
  output logic [DATA_W-1:0] pdata,
  output logic              bad_event
);

  logic [31:0] code_q;
  logic [31:0] code_prev;
  logic        evt;

  assign evt       = (code_q != code_prev);
  assign bad_event = evt && (code_q > LOC3);

  // A fresh event wins over a same-cycle grant: the grant takes the old entry, the new one stays pending.
  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      code_q    <= NONE;
      code_prev <= NONE;
      pending   <= 1'b0;
      slot      <= 2'd0;
      pdata     <= '0;
    end else begin
      code_q    <= code;
      code_prev <= code_q;
      if (evt && code_is_slot(code_q)) begin
        pending <= 1'b1;
        slot    <= 2'(code_q - LOC1);
        pdata   <= data;
      end else if (grant) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/slot_save_load_ctrl.sv
// rtl/slot_save_load_ctrl.sv - arbitrates save/load slot requests onto a single req/ack slot memory port
// Define SLOT_READBACK_EN to verify every acked write with an automatic read of the same slot.
module slot_save_load_ctrl
  import slot_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic [31:0]       save_signal,
  input  logic [31:0]       load_signal,
  input  logic [DATA_W-1:0] sensor_input_to_save,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] sensor_output,
  output logic              load_valid,
  output logic              busy,
  output logic              err
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t             state;
  logic               prio_save;
  logic [CNT_W-1:0]   tmo_cnt;
  logic               save_pend, load_pend;
  logic [1:0]         save_slot, load_slot;
  logic [DATA_W-1:0]  save_pdata, load_pdata;
  logic               save_bad, load_bad;
  logic               grant_save, grant_load, grant_any;
  op_t                grant_op;

  slot_req_detect #(.DATA_W(DATA_W)) u_save_det (
    .iVGA_CLK (iVGA_CLK),
    .iRST_n   (iRST_n),
    .code     (save_signal),
    .data     (sensor_input_to_save),
    .grant    (grant_save),
    .pending  (save_pend),
    .slot     (save_slot),
    .pdata    (save_pdata),
    .bad_event(save_bad)
  );

  slot_req_detect #(.DATA_W(DATA_W)) u_load_det (
    .iVGA_CLK (iVGA_CLK),
    .iRST_n   (iRST_n),
    .code     (load_signal),
    .data     ('0),
    .grant    (grant_load),
    .pending  (load_pend),
    .slot     (load_slot),
    .pdata    (load_pdata),
    .bad_event(load_bad)
  );

  always_comb begin
    grant_save = 1'b0;
    grant_load = 1'b0;
    if (state == ST_IDLE) begin
      if (save_pend && (!load_pend || prio_save)) grant_save = 1'b1;
      else if (load_pend)                          grant_load = 1'b1;
    end
    grant_any = grant_save || grant_load;
    grant_op  = grant_save ? OP_SAVE : OP_LOAD;
  end

  assign busy = (state != ST_IDLE) || save_pend || load_pend;

  always_ff @(posedge iVGA_CLK) begin
    if (!iRST_n) begin
      state         <= ST_IDLE;
      prio_save     <= 1'b1;
      tmo_cnt       <= '0;
      mem_req       <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= 2'd0;
      mem_wdata     <= '0;
      sensor_output <= '0;
      load_valid    <= 1'b0;
      err           <= 1'b0;
    end else begin
      load_valid <= 1'b0;
      if (save_bad || load_bad) err <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (mem_ack) err <= 1'b1;
          if (grant_any) begin
            mem_req   <= 1'b1;
            mem_we    <= (grant_op == OP_SAVE);
            mem_addr  <= (grant_op == OP_SAVE) ? save_slot : load_slot;
            mem_wdata <= (grant_op == OP_SAVE) ? save_pdata : load_pdata;
            prio_save <= ~prio_save;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE, ST_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              sensor_output <= mem_rdata;
              load_valid    <= 1'b1;
              state         <= ST_DONE;
            end else begin
`ifdef SLOT_READBACK_EN
              state <= ST_VERIFY;
`else
              state <= ST_IDLE;
`endif
            end
          end else if (state == ST_ISSUE) begin
            tmo_cnt <= '0;
            state   <= ST_WAIT;
          end else if (tmo_cnt == TMO_LAST) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
`ifdef SLOT_READBACK_EN
        // mem_req low marks the issue cycle of the readback; mem_wdata still holds the written value.
        ST_VERIFY: begin
          if (!mem_req) begin
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
            tmo_cnt <= '0;
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            if (mem_rdata != mem_wdata) err <= 1'b1;
            state <= ST_IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            mem_req <= 1'b0;
            err     <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
